pipe_elastic_regs: RTL and testbench
====================================

Name: pipe_elastic_regs

Overview:
- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB register banks in the 5-stage core.
- Provides a chain of STAGES pipeline registers with per-stage valid bits and valid/ready backpressure.
- Each stage has its own hold (stall, with bubble insertion) and flush (kill) control.
- Instantiated once per datapath slice; the hazard unit drives hold/flush in place of the hand-coded Stall/IF_flush muxes.

Parameters:
- STAGES, 4, number of register stages (1..8).
- WIDTH, 32, payload bits per stage.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream item present.
- in_ready  out  1  stage 0 can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  last stage presents an item.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  last-stage payload.
- hold  in  STAGES  hold[i]=1: stage i keeps its item; the stage after it receives a bubble.
- flush  in  STAGES  flush[i]=1: stage i is emptied at the next edge.
- stage_valid  out  STAGES  valid bit of each stage, for the hazard unit.
- cnt_stall  out  CNT_W  optional, see Optional Feature.
- cnt_kill  out  CNT_W  optional, see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous): every valid bit = 0 and every data register = 0. Hence out_valid=0, out_data=0, stage_valid=0, counters=0.
- Define rdy[STAGES] = out_ready.
- adv[i] = valid[i] & ~hold[i] & rdy[i+1].
- rdy[i] = ~valid[i] | adv[i]. This is a combinational ready chain, with no extra cycle.
- in_ready = rdy[0].
- out_valid = valid[STAGES-1] & ~hold[STAGES-1].
- out_data = data[STAGES-1].
- Stage i loads (valid and data) when its source is offered and rdy[i]=1:
  - the source for stage 0 is in_valid/in_data;
  - the source for stage i>0 is adv[i-1]/data[i-1].
- If rdy[i]=1 and nothing is offered, valid[i] becomes 0 (bubble). Data is left unchanged.
- If rdy[i]=0, stage i keeps both valid and data.
- Hold: a held full stage keeps its item. If the next stage drains or is empty, it receives a bubble. Upstream stages back up through rdy.
- Flush priority: flush[i] overrides everything for stage i.
  - valid[i] is 0 after the edge.
  - Any item moving into stage i that cycle is discarded, but still counts as accepted upstream: the in_valid & in_ready handshake completes.
- Flush and hold on the same stage: the flush wins.
- Flushing stage i does not change rdy[i] in that same cycle, so there is no combinational path from flush to in_ready.
- Latency: with no hold, flush or backpressure, an item accepted at edge n appears on out_valid after edge n+STAGES-1, i.e. STAGES cycles of register delay. Full throughput is one item per cycle.
- Full pipeline with out_ready=0: in_ready=0 and all data is stable. When out_ready rises, every stage advances in the same cycle.
- Deasserting reset mid-stream: the pipeline restarts empty. No partial items survive.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined:
  - cnt_stall increments on each cycle with in_valid & ~in_ready.
  - cnt_kill increments by 1 on each cycle in which at least one valid item is flushed.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: cnt_stall and cnt_kill are tied to 0, and no counter flops are generated.

Decomposition:
- Shared package pipe_defs holds:
  - limits STAGES_MAX=8 and CNT_W_DEF=16;
  - localparam encodings for the hazard unit: HOLD_NONE=0 and the per-stage masks for IF, ID, EX, MEM and WB in a 5-stage configuration.
- Natural sub-module: pipe_slot. It holds one stage's valid/data flops with the load/bubble/flush logic, and is instantiated STAGES times in a generate loop. The ready chain and counters stay in the parent.

Test Plan:
- Streaming, STAGES=4, out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 with out_valid high on three consecutive cycles, the first appearing 4 cycles after acceptance; in_ready stays 1.
- Backpressure: fill with 0xA0..0xA3, then out_ready=0 for 5 cycles -> in_ready=0, out_data holds 0xA0, stage_valid=4'b1111. Raise out_ready -> 0xA0..0xA3 emerge in order with no loss or duplication.
- Hold with bubble: hold[1]=1 for 2 cycles while streaming 0x01..0x06 -> stage 2 becomes empty for exactly 2 cycles; the output sequence is 0x01..0x06 with a 2-cycle gap and no reordering.
- Flush plus simultaneous accept: pipeline full, flush=4'b0011 in the same cycle as in_valid=1 with 0xFF -> in_ready handshake completes and 0xFF never appears at the output. Stages 0-1 are empty next cycle; items in stages 2-3 still exit.
- Asynchronous reset mid-stream: assert reset=0 between clock edges with 3 items in flight -> stage_valid=0 and out_data=0 immediately. After release, the first new input exits after 4 cycles.
- PIPE_PERF_EN, CNT_W=4: hold out_ready=0 with in_valid=1 for 20 cycles -> cnt_stall saturates at 15. One flush of 2 valid stages -> cnt_kill=1.

Source files
------------

// File: rtl/pipe_elastic_regs_pkg.sv
// Shared limits and hazard-unit hold/flush encodings for pipe_elastic_regs.
// Masks assume the classic 5-stage IF/ID/EX/MEM/WB configuration.
package pipe_defs;

    localparam int STAGES_MAX = 8;
    localparam int CNT_W_DEF  = 16;

    localparam logic [4:0] HOLD_NONE = 5'b00000;
    localparam logic [4:0] HOLD_IF   = 5'b00001;
    localparam logic [4:0] HOLD_ID   = 5'b00010;
    localparam logic [4:0] HOLD_EX   = 5'b00100;
    localparam logic [4:0] HOLD_MEM  = 5'b01000;
    localparam logic [4:0] HOLD_WB   = 5'b10000;

endpackage

// File: rtl/pipe_elastic_regs_if.sv
// Upstream/downstream valid/ready bundle for pipe_elastic_regs.
// master = producer/consumer side (testbench or core), slave = the register chain.
interface pipe_elastic_regs_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_elastic_regs_slot.sv
// One pipeline register: valid/data flops with load, bubble and flush handling.
// Data only moves on an accepted, non-flushed load; bubbles leave it untouched.
module pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             offer,
    input  logic [WIDTH-1:0] src_data,
    input  logic             rdy,
    input  logic             flush,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            // flush beats both hold (rdy=0) and an incoming item
            if (flush)
                valid <= 1'b0;
            else if (rdy)
                valid <= offer;
            if (rdy && offer && !flush)
                data <= src_data;
        end
    end

endmodule

// File: rtl/pipe_elastic_regs.sv
// Parametrised chain of STAGES elastic pipeline registers with per-stage hold/flush.
// Optional saturating stall/kill counters are built only when PIPE_PERF_EN is defined.
module pipe_elastic_regs
    import pipe_defs::*;
#(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pipe_elastic_regs_if.slave  bus,
    input  logic [STAGES-1:0]   hold,
    input  logic [STAGES-1:0]   flush,
    output logic [STAGES-1:0]   stage_valid,
    output logic [CNT_W-1:0]    cnt_stall,
    output logic [CNT_W-1:0]    cnt_kill
);

    logic [STAGES:0]              rdy;
    logic [STAGES-1:0]            adv;
    logic [STAGES-1:0]            offer;
    logic [STAGES-1:0]            valid;
    logic [STAGES-1:0][WIDTH-1:0] data;
    logic [STAGES-1:0][WIDTH-1:0] src;

    // Ready ripples from the output back to stage 0 in the same cycle;
    // flush is deliberately absent so it never reaches in_ready.
    always_comb begin
        rdy         = '0;
        adv         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = valid[i] & ~hold[i] & rdy[i+1];
            rdy[i] = ~valid[i] | adv[i];
        end
    end

    always_comb begin
        offer    = '0;
        src      = '0;
        offer[0] = bus.in_valid;
        src[0]   = bus.in_data;
        for (int i = 1; i < STAGES; i++) begin
            offer[i] = adv[i-1];
            src[i]   = data[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .offer    (offer[g]),
            .src_data (src[g]),
            .rdy      (rdy[g]),
            .flush    (flush[g]),
            .valid    (valid[g]),
            .data     (data[g])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = valid[STAGES-1] & ~hold[STAGES-1];
    assign bus.out_data  = data[STAGES-1];
    assign stage_valid   = valid;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] kill_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            kill_q  <= '0;
        end else begin
            if (bus.in_valid && !rdy[0] && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            // one count per cycle, however many occupied stages are killed
            if ((|(flush & valid)) && (kill_q != '1))
                kill_q <= kill_q + 1'b1;
        end
    end

    assign cnt_stall = stall_q;
    assign cnt_kill  = kill_q;
`else
    assign cnt_stall = '0;
    assign cnt_kill  = '0;
`endif

endmodule

// File: tb/tb_pipe_elastic_regs.sv
// Directed-vector bench for pipe_elastic_regs (STAGES=4): streaming, backpressure,
// hold bubbles, flush with accept, mid-stream async reset, and the PIPE_PERF_EN counters.
module tb_pipe_elastic_regs;

    localparam int STAGES = 4;
    localparam int WIDTH  = 32;
    localparam int CNT_W  = 4;
`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [STAGES-1:0] hold = '0;
    logic [STAGES-1:0] flush = '0;
    logic [STAGES-1:0] stage_valid;
    logic [CNT_W-1:0]  cnt_stall;
    logic [CNT_W-1:0]  cnt_kill;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    string scn   = "reset";

    pipe_elastic_regs_if #(.WIDTH(WIDTH)) bus ();

    pipe_elastic_regs #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .hold        (hold),
        .flush       (flush),
        .stage_valid (stage_valid),
        .cnt_stall   (cnt_stall),
        .cnt_kill    (cnt_kill)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic v(input logic iv, input logic [7:0] id, input logic ordy,
                     input logic [3:0] h, input logic [3:0] f,
                     input logic e_irdy, input logic e_ov, input logic [7:0] e_od,
                     input logic [3:0] e_sv);
        bus.in_valid  = iv;
        bus.in_data   = {24'h0, id};
        bus.out_ready = ordy;
        hold          = h;
        flush         = f;
        @(negedge clk);
        chk($sformatf("%s.c%0d.in_ready", scn, cyc), {31'h0, bus.in_ready}, {31'h0, e_irdy});
        chk($sformatf("%s.c%0d.out_valid", scn, cyc), {31'h0, bus.out_valid}, {31'h0, e_ov});
        if (e_ov)
            chk($sformatf("%s.c%0d.out_data", scn, cyc), bus.out_data, {24'h0, e_od});
        chk($sformatf("%s.c%0d.stage_valid", scn, cyc), {28'h0, stage_valid}, {28'h0, e_sv});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called at posedge+1; reset pulses fully between edges.
    task automatic pulse_rst(input string name);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; hold = '0; flush = '0;
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        scn = name;
        cyc = 0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        @(posedge clk);
        #1;
        chk("reset.stage_valid", {28'h0, stage_valid}, 32'h0);
        chk("reset.out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("reset.out_data", bus.out_data, 32'h0);
        chk("reset.in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("reset.cnt_stall", {28'h0, cnt_stall}, 32'h0);
        chk("reset.cnt_kill", {28'h0, cnt_kill}, 32'h0);
        #2 reset = 1'b1;

        scn = "stream"; cyc = 0;
        v(1, 8'h11, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0000);
        v(1, 8'h22, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0001);
        v(1, 8'h33, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0011);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0111);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'h11, 4'b1110);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'h22, 4'b1100);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'h33, 4'b1000);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0000);

        pulse_rst("bp");
        v(1, 8'hA0, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0000);
        v(1, 8'hA1, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0001);
        v(1, 8'hA2, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0011);
        v(1, 8'hA3, 0, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0111);
        for (int k = 0; k < 5; k++)
            v(0, 8'h00, 0, 4'h0, 4'h0, 0, 1, 8'hA0, 4'b1111);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'hA0, 4'b1111);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'hA1, 4'b1110);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'hA2, 4'b1100);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'hA3, 4'b1000);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0000);

        pulse_rst("hold");
        v(1, 8'h01, 1, 4'h0,    4'h0, 1, 0, 8'h00, 4'b0000);
        v(1, 8'h02, 1, 4'h0,    4'h0, 1, 0, 8'h00, 4'b0001);
        v(1, 8'h03, 1, 4'h0,    4'h0, 1, 0, 8'h00, 4'b0011);
        v(1, 8'h04, 1, 4'b0010, 4'h0, 0, 0, 8'h00, 4'b0111);
        v(1, 8'h04, 1, 4'b0010, 4'h0, 0, 1, 8'h01, 4'b1011);
        v(1, 8'h04, 1, 4'h0,    4'h0, 1, 0, 8'h00, 4'b0011);
        v(1, 8'h05, 1, 4'h0,    4'h0, 1, 0, 8'h00, 4'b0111);
        v(1, 8'h06, 1, 4'h0,    4'h0, 1, 1, 8'h02, 4'b1111);
        v(0, 8'h00, 1, 4'h0,    4'h0, 1, 1, 8'h03, 4'b1111);
        v(0, 8'h00, 1, 4'h0,    4'h0, 1, 1, 8'h04, 4'b1110);
        v(0, 8'h00, 1, 4'h0,    4'h0, 1, 1, 8'h05, 4'b1100);
        v(0, 8'h00, 1, 4'h0,    4'h0, 1, 1, 8'h06, 4'b1000);
        v(0, 8'h00, 1, 4'h0,    4'h0, 1, 0, 8'h00, 4'b0000);

        pulse_rst("flush");
        v(1, 8'hB0, 1, 4'h0, 4'h0,    1, 0, 8'h00, 4'b0000);
        v(1, 8'hB1, 1, 4'h0, 4'h0,    1, 0, 8'h00, 4'b0001);
        v(1, 8'hB2, 1, 4'h0, 4'h0,    1, 0, 8'h00, 4'b0011);
        v(1, 8'hB3, 1, 4'h0, 4'h0,    1, 0, 8'h00, 4'b0111);
        v(1, 8'hFF, 1, 4'h0, 4'b0011, 1, 1, 8'hB0, 4'b1111);
        v(0, 8'h00, 1, 4'h0, 4'h0,    1, 1, 8'hB1, 4'b1100);
        v(0, 8'h00, 1, 4'h0, 4'h0,    1, 1, 8'hB2, 4'b1000);
        v(0, 8'h00, 1, 4'h0, 4'h0,    1, 0, 8'h00, 4'b0000);

        // no reset here: last-stage data still holds 0xB2, so the async clear is visible
        scn = "rst_mid"; cyc = 0;
        v(1, 8'hC1, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0000);
        v(1, 8'hC2, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0001);
        v(1, 8'hC3, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0011);
        bus.in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_mid.stage_valid", {28'h0, stage_valid}, 32'h0);
        chk("rst_mid.out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_mid.out_data", bus.out_data, 32'h0);
        #1 reset = 1'b1;
        scn = "restart"; cyc = 0;
        v(1, 8'h5A, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0000);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0001);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0010);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0100);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 1, 8'h5A, 4'b1000);
        v(0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 8'h00, 4'b0000);

        // counters: 4 fill cycles, then 16 stalled cycles saturate a 4-bit counter
        pulse_rst("perf");
        for (int k = 0; k < 20; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'hD0 + k;
            bus.out_ready = 1'b0;
            @(posedge clk);
            #1;
            if (k == 9)
                chk("perf.cnt_stall_mid", {28'h0, cnt_stall}, PERF ? 32'd6 : 32'd0);
        end
        chk("perf.cnt_stall_sat", {28'h0, cnt_stall}, PERF ? 32'd15 : 32'd0);
        chk("perf.cnt_kill_pre", {28'h0, cnt_kill}, 32'd0);
        bus.in_valid = 1'b0;
        flush = 4'b0011;
        @(posedge clk);
        #1;
        flush = 4'b0000;
        chk("perf.sv_after_flush", {28'h0, stage_valid}, 32'b1100);
        chk("perf.cnt_kill", {28'h0, cnt_kill}, PERF ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        chk("perf.cnt_kill_hold", {28'h0, cnt_kill}, PERF ? 32'd1 : 32'd0);
        chk("perf.cnt_stall_hold", {28'h0, cnt_stall}, PERF ? 32'd15 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
